// File: rtl/cadr_clock_pkg.sv
// -----------------------------------------------------------------------------
// cadr_clock_pkg
// Shared definitions for the CADR counter-based clock sequencer:
//   - state_e      : sequencer state (IDLE / RUN / HUNG)
//   - READ_NS      : read-phase length in ns, indexed by {sspeed[1],sspeed[0],ilong}
//   - ns_to_ticks  : converts a ns constant into reference-clock ticks
// -----------------------------------------------------------------------------
package cadr_clock_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HUNG = 2'd2
  } state_e;

  // Read-phase lengths taken from the original delay-line taps.
  localparam int unsigned READ_NS [8] = '{160, 160, 140, 100, 125, 85, 115, 75};

  // Every ns constant is a whole multiple of the tick, so this divides exactly.
  function automatic int unsigned ns_to_ticks(input int unsigned ns,
                                              input int unsigned tick_ns);
    return ns / tick_ns;
  endfunction

endpackage

// File: rtl/cadr_clock_seq_if.sv
// -----------------------------------------------------------------------------
// cadr_clock_seq_if
// Bundles the control inputs and strobe outputs of cadr_clock_seq.
//   master : drives sspeed, ilong, hang_n (and step_mode/step), observes strobes
//   slave  : the sequencer itself
// Optional macro CADR_CLOCK_STEP_EN adds step_mode and step.
// -----------------------------------------------------------------------------
interface cadr_clock_seq_if;
  logic [1:0] sspeed;
  logic       ilong;
  logic       hang_n;
`ifdef CADR_CLOCK_STEP_EN
  logic       step_mode;
  logic       step;
`endif
  logic       tpr0;
  logic       tpclk;
  logic       tprend;
  logic       tpwp;
  logic       cycle_completed;
  logic       running;
  logic [2:0] sel_q;

`ifdef CADR_CLOCK_STEP_EN
  modport master (
    output sspeed, ilong, hang_n, step_mode, step,
    input  tpr0, tpclk, tprend, tpwp, cycle_completed, running, sel_q
  );
  modport slave (
    input  sspeed, ilong, hang_n, step_mode, step,
    output tpr0, tpclk, tprend, tpwp, cycle_completed, running, sel_q
  );
`else
  modport master (
    output sspeed, ilong, hang_n,
    input  tpr0, tpclk, tprend, tpwp, cycle_completed, running, sel_q
  );
  modport slave (
    input  sspeed, ilong, hang_n,
    output tpr0, tpclk, tprend, tpwp, cycle_completed, running, sel_q
  );
`endif
endinterface

// File: rtl/cadr_clock_len_rom.sv
// -----------------------------------------------------------------------------
// cadr_clock_len_rom
// Combinational map from the 3-bit speed select to cycle timing in ticks.
//   sel_i : {sspeed[1], sspeed[0], ilong}
//   r_o   : read-phase length R (tick index of tprend)
//   p_o   : full cycle length P = R + write-phase ticks
// -----------------------------------------------------------------------------
module cadr_clock_len_rom
  import cadr_clock_pkg::*;
#(
  parameter int unsigned TICK_NS = 5,
  parameter int unsigned TPW_NS  = 60,
  parameter int unsigned CNT_W   = 8
) (
  input  logic [2:0]       sel_i,
  output logic [CNT_W-1:0] r_o,
  output logic [CNT_W-1:0] p_o
);

  localparam logic [CNT_W-1:0] PW_T = CNT_W'(ns_to_ticks(TPW_NS, TICK_NS));

  // Table is folded to constants at elaboration; only the 8:1 mux remains.
  logic [CNT_W-1:0] r_tab [8];

  for (genvar i = 0; i < 8; i++) begin : g_tab
    assign r_tab[i] = CNT_W'(ns_to_ticks(READ_NS[i], TICK_NS));
  end

  assign r_o = r_tab[sel_i];
  assign p_o = r_tab[sel_i] + PW_T;

endmodule

// File: rtl/cadr_clock_seq.sv
// -----------------------------------------------------------------------------
// cadr_clock_seq
// Counter-based replacement for the CADR delay-line clock generator. Each
// machine cycle is a read phase (length chosen by {sspeed,ilong}) followed by
// a fixed write phase; hang_n low stalls between cycles.
// Ports:
//   clk   : reference clock (one tick = TICK_NS)
//   reset : synchronous, active-high
//   bus   : cadr_clock_seq_if.slave (sspeed, ilong, hang_n in;
//           tpr0, tpclk, tprend, tpwp, cycle_completed, running, sel_q out)
// Optional macro CADR_CLOCK_STEP_EN: adds step_mode/step single-cycle stepping.
// -----------------------------------------------------------------------------
module cadr_clock_seq
  import cadr_clock_pkg::*;
#(
  parameter int unsigned TICK_NS       = 5,
  parameter int unsigned TPCLK_NS      = 40,
  parameter int unsigned TPW_NS        = 60,
  parameter int unsigned TPWP_START_NS = 10,
  parameter int unsigned TPWP_END_NS   = 30,
  parameter int unsigned CNT_W         = 8
) (
  input  logic             clk,
  input  logic             reset,
  cadr_clock_seq_if.slave  bus
);

  localparam logic [CNT_W-1:0] TPCLK_T = CNT_W'(ns_to_ticks(TPCLK_NS, TICK_NS));
  localparam logic [CNT_W-1:0] WPS_T   = CNT_W'(ns_to_ticks(TPWP_START_NS, TICK_NS));
  localparam logic [CNT_W-1:0] WPE_T   = CNT_W'(ns_to_ticks(TPWP_END_NS, TICK_NS));
  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] t_q, t_d;
  logic [CNT_W-1:0] p_q;
  logic [CNT_W-1:0] r_d, p_d;
  logic [2:0]       sel_q, sel_d, sel_in;
  logic             go;

  logic tpr0_q, tpr0_d;
  logic tpclk_q, tpclk_d;
  logic tprend_q, tprend_d;
  logic tpwp_q, tpwp_d;
  logic cc_q, cc_d;
  logic running_q, running_d;

  assign sel_in = {bus.sspeed, bus.ilong};

  // Permission to start the next cycle (end of cycle or leaving HUNG).
`ifdef CADR_CLOCK_STEP_EN
  logic step_q;

  // Rising-edge detect so a held step yields a single cycle.
  always_ff @(posedge clk) begin
    if (reset) step_q <= 1'b0;
    else       step_q <= bus.step;
  end

  assign go = bus.hang_n & (~bus.step_mode | (bus.step & ~step_q));
`else
  assign go = bus.hang_n;
`endif

  // Timing for the cycle that will be current after this edge.
  cadr_clock_len_rom #(
    .TICK_NS (TICK_NS),
    .TPW_NS  (TPW_NS),
    .CNT_W   (CNT_W)
  ) u_len_rom (
    .sel_i (sel_d),
    .r_o   (r_d),
    .p_o   (p_d)
  );

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      t_q       <= '0;
      p_q       <= '0;
      sel_q     <= '0;
      tpr0_q    <= 1'b0;
      tpclk_q   <= 1'b0;
      tprend_q  <= 1'b0;
      tpwp_q    <= 1'b0;
      cc_q      <= 1'b0;
      running_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      t_q       <= t_d;
      p_q       <= p_d;
      sel_q     <= sel_d;
      tpr0_q    <= tpr0_d;
      tpclk_q   <= tpclk_d;
      tprend_q  <= tprend_d;
      tpwp_q    <= tpwp_d;
      cc_q      <= cc_d;
      running_q <= running_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    t_d     = t_q;
    sel_d   = sel_q;
    unique case (state_q)
      ST_IDLE: begin
        state_d = ST_RUN;
        t_d     = '0;
        sel_d   = sel_in;
      end
      ST_RUN: begin
        if (t_q < p_q - ONE) begin
          t_d = t_q + ONE;
        end else if (go) begin
          t_d   = '0;
          sel_d = sel_in;
        end else begin
          state_d = ST_HUNG;
          t_d     = '0;
        end
      end
      ST_HUNG: begin
        if (go) begin
          state_d = ST_RUN;
          t_d     = '0;
          sel_d   = sel_in;
        end
      end
      default: begin
        state_d = ST_IDLE;
        t_d     = '0;
      end
    endcase
  end

  // Output decode, registered so strobes line up with t_q
  always_comb begin
    running_d = (state_d == ST_RUN);
    tpr0_d    = running_d && (t_d == '0);
    tpclk_d   = running_d && (t_d < TPCLK_T);
    tprend_d  = running_d && (t_d == r_d);
    tpwp_d    = running_d && (t_d >= r_d + WPS_T) && (t_d < r_d + WPE_T);
    cc_d      = running_d && (t_d == p_d - ONE);
  end

  assign bus.tpr0            = tpr0_q;
  assign bus.tpclk           = tpclk_q;
  assign bus.tprend          = tprend_q;
  assign bus.tpwp            = tpwp_q;
  assign bus.cycle_completed = cc_q;
  assign bus.running         = running_q;
  assign bus.sel_q           = sel_q;

endmodule

// File: tb/tb_cadr_clock_seq.sv
module tb_cadr_clock_seq;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  cadr_clock_seq_if bus ();

  cadr_clock_seq dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Hand-computed cycle lengths in ticks for sel 0..7 at TICK_NS=5.
  int period_tab [8] = '{44, 44, 40, 32, 37, 29, 35, 27};

  // {tpr0, tpclk, tprend, tpwp, cycle_completed, running, sel_q}
  function automatic logic [8:0] outs();
    return {bus.tpr0, bus.tpclk, bus.tprend, bus.tpwp,
            bus.cycle_completed, bus.running, bus.sel_q};
  endfunction

  task automatic set_sel(input int s);
    bus.sspeed = 2'(s >> 1);
    bus.ilong  = 1'(s & 1);
  endtask

  // Advance at least one tick, stop at the next negedge showing tpr0.
  task automatic wait_tpr0(input string name);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (bus.tpr0 !== 1'b1 && n < 100);
    checks++;
    if (bus.tpr0 !== 1'b1) begin
      errors++;
      $display("FAIL %s: tpr0 never seen, got %b want 1", name, bus.tpr0);
    end
  endtask

  task automatic measure(input int start, output int n);
    n = start;
    do begin
      @(negedge clk);
      n++;
    end while (bus.tpr0 !== 1'b1 && n < 200);
  endtask

  task automatic test_reset();
    logic [8:0] exp;
    reset = 1'b1;
    bus.hang_n = 1'b1;
    set_sel(7);
    repeat (40) @(negedge clk);
    checks++;
    if (outs() !== 9'd0) begin
      errors++;
      $display("FAIL reset_state: got %b want %b", outs(), 9'd0);
    end
    reset = 1'b0;
    for (int k = 0; k <= 27; k++) begin
      @(negedge clk);
      exp = {(k == 0 || k == 27), (k < 8 || k == 27), (k == 15),
             (k >= 17 && k <= 20), (k == 26), 1'b1, 3'd7};
      checks++;
      if (outs() !== exp) begin
        errors++;
        $display("FAIL first_cycle t=%0d: got %b want %b", k, outs(), exp);
      end
    end
  endtask

  task automatic test_sweep();
    int n;
    for (int s = 0; s < 8; s++) begin
      set_sel(s);
      wait_tpr0("sweep_sync");
      checks++;
      if (bus.sel_q !== 3'(s)) begin
        errors++;
        $display("FAIL sweep_sel: got %0d want %0d", bus.sel_q, s);
      end
      for (int c = 0; c < 2; c++) begin
        measure(0, n);
        checks++;
        if (n !== period_tab[s]) begin
          errors++;
          $display("FAIL sweep_period sel=%0d: got %0d want %0d", s, n, period_tab[s]);
        end
      end
    end
  endtask

  task automatic test_speed_change();
    int n;
    set_sel(3);
    wait_tpr0("chg_sync");
    checks++;
    if (bus.sel_q !== 3'd3) begin
      errors++;
      $display("FAIL chg_sel_before: got %0d want 3", bus.sel_q);
    end
    repeat (5) @(negedge clk);
    set_sel(0);
    measure(5, n);
    checks++;
    if (n !== 32) begin
      errors++;
      $display("FAIL chg_cur_period: got %0d want 32", n);
    end
    checks++;
    if (bus.sel_q !== 3'd0) begin
      errors++;
      $display("FAIL chg_sel_after: got %0d want 0", bus.sel_q);
    end
    measure(0, n);
    checks++;
    if (n !== 44) begin
      errors++;
      $display("FAIL chg_next_period: got %0d want 44", n);
    end
  endtask

  task automatic test_hang();
    set_sel(7);
    wait_tpr0("hang_sync");
    repeat (10) @(negedge clk);
    bus.hang_n = 1'b0;
    for (int i = 1; i <= 50; i++) begin
      @(negedge clk);
      if (i == 16) begin
        checks++;
        if (bus.cycle_completed !== 1'b1) begin
          errors++;
          $display("FAIL hang_complete: got %b want 1", bus.cycle_completed);
        end
      end else if (i > 16) begin
        checks++;
        if (outs() >> 3 !== 9'd0) begin
          errors++;
          $display("FAIL hang_quiet i=%0d: got %b want 000000", i, outs() >> 3);
        end
      end
    end
    bus.hang_n = 1'b1;
    @(negedge clk);
    checks++;
    if ({bus.tpr0, bus.running} !== 2'b11) begin
      errors++;
      $display("FAIL hang_resume: got %b want 11", {bus.tpr0, bus.running});
    end
  endtask

  task automatic test_reset_mid();
    int n;
    set_sel(0);
    wait_tpr0("rmid_sync");
    repeat (20) @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++;
      if (outs() !== 9'd0) begin
        errors++;
        $display("FAIL rmid_clear %0d: got %b want %b", i, outs(), 9'd0);
      end
    end
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (outs() !== 9'b110001000) begin
      errors++;
      $display("FAIL rmid_restart: got %b want %b", outs(), 9'b110001000);
    end
    measure(0, n);
    checks++;
    if (n !== 44) begin
      errors++;
      $display("FAIL rmid_period: got %0d want 44", n);
    end
  endtask

`ifdef CADR_CLOCK_STEP_EN
  task automatic test_step();
    int cc;
    bus.step_mode = 1'b1;
    bus.step      = 1'b0;
    set_sel(7);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    cc = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.cycle_completed === 1'b1) cc++;
    end
    checks++;
    if (cc !== 1 || bus.running !== 1'b0) begin
      errors++;
      $display("FAIL step_free_cycle: got cc=%0d running=%b want cc=1 running=0", cc, bus.running);
    end
    cc = 0;
    for (int k = 0; k < 3; k++) begin
      bus.step = 1'b1;
      @(negedge clk);
      if (bus.cycle_completed === 1'b1) cc++;
      bus.step = 1'b0;
      repeat (34) begin
        @(negedge clk);
        if (bus.cycle_completed === 1'b1) cc++;
      end
    end
    checks++;
    if (cc !== 3) begin
      errors++;
      $display("FAIL step_pulses: got %0d cycles want 3", cc);
    end
    cc = 0;
    bus.step = 1'b1;
    repeat (100) begin
      @(negedge clk);
      if (bus.cycle_completed === 1'b1) cc++;
    end
    bus.step = 1'b0;
    checks++;
    if (cc !== 1 || bus.running !== 1'b0) begin
      errors++;
      $display("FAIL step_held: got cc=%0d running=%b want cc=1 running=0", cc, bus.running);
    end
    bus.step_mode = 1'b0;
  endtask
`endif

  initial begin
    reset      = 1'b1;
    bus.hang_n = 1'b1;
    set_sel(0);
`ifdef CADR_CLOCK_STEP_EN
    bus.step_mode = 1'b0;
    bus.step      = 1'b0;
`endif
    test_reset();
    test_sweep();
    test_speed_change();
    test_hang();
    test_reset_mid();
`ifdef CADR_CLOCK_STEP_EN
    test_step();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cadr_clock_seq.md
Name: cadr_clock_seq

Overview:
- Synchronous, counter-based replacement for the CADR delay-line clock generator (the TD25/TD50/TD100 chains and the 74S151 speed mux).
- Runs from one fast reference clock and sequences each machine cycle in two parts: a read phase, whose length is picked by sspeed/ilong, then a fixed write phase.
- Emits the cycle-start, clock, write-pulse and completion strobes that the CADR datapath consumes.
- Honours hang (stall between cycles).

Parameters:
- TICK_NS, 5, reference clock period in ns; every ns constant must be divisible by it.
- TPCLK_NS, 40, tpclk high time from cycle start.
- TPW_NS, 60, write phase length (TPREND to TPDONE).
- TPWP_START_NS, 10, tpwp rise offset after TPREND.
- TPWP_END_NS, 30, tpwp fall offset after TPREND.
- CNT_W, 8, width of the tick counter.

Ports:
- clk  in  1  reference clock.
- reset  in  1  synchronous reset, active-high.
- sspeed  in  2  speed select.
- ilong  in  1  long-instruction select.
- hang_n  in  1  low = stall after the current cycle.
- tpr0  out  1  one-tick pulse at cycle start.
- tpclk  out  1  machine clock.
- tprend  out  1  one-tick pulse at end of the read phase.
- tpwp  out  1  write pulse.
- cycle_completed  out  1  one-tick pulse on the last tick of the cycle.
- running  out  1  high in RUN.
- sel_q  out  3  latched {sspeed,ilong} for the current cycle.

Behaviour:
- States: IDLE, RUN, HUNG.
- Reset:
  - On any clk edge with reset=1: state=IDLE, t=0, every output 0, sel_q=0.
  - Reset mid-cycle aborts the cycle at that edge.
- Start:
  - First edge with reset=0 in IDLE: enter RUN with t=0.
  - sel_q is latched from {sspeed[1],sspeed[0],ilong].
- Read-phase length R (ticks) by sel index, in ns/TICK_NS:
  - 0:160, 1:160, 2:140, 3:100, 4:125, 5:85, 6:115, 7:75.
  - At the default TICK_NS: R = 32, 32, 28, 20, 25, 17, 23, 15.
- Cycle length P = R + TPW_NS/TICK_NS (default R+12).
- RUN outputs, all registered and valid in the same tick as t:
  - tpr0 = (t==0)
  - tpclk = (t < TPCLK_NS/TICK_NS)
  - tprend = (t==R)
  - tpwp = (R+2 <= t < R+6) at defaults
  - cycle_completed = (t==P-1)
- Counter advance: t increments each tick while t<P-1.
- At t==P-1:
  - hang_n=1: t=0 next tick, sel_q re-latched, new cycle.
  - hang_n=0: go to HUNG.
- HUNG:
  - All strobes 0, running=0.
  - First tick hang_n=1: go to RUN with t=0 and sel_q latched.
- Speed/ilong changes mid-cycle are ignored. They take effect only at the next t==0 latch.
- hang_n is sampled only at t==P-1 and in HUNG.
- Counter never wraps: P is at most 44 at defaults, below 2^CNT_W.

Optional Feature:
- Macro: CADR_CLOCK_STEP_EN.
- When defined, adds ports step_mode (in, 1) and step (in, 1).
  - With step_mode=1, the transition at t==P-1 (and out of HUNG) also requires step=1 on that tick; otherwise the block waits in HUNG.
  - One step pulse gives exactly one cycle.
  - A step held high for N ticks still gives one cycle: step is edge-detected in a register that reset clears.
- When undefined, the ports are absent and behaviour equals step_mode=0.

Decomposition:
- Package cadr_clock_pkg holds:
  - state enum (IDLE/RUN/HUNG)
  - read-phase ns table, 8 entries
  - ns-to-tick conversion function
- One natural sub-module: cadr_clock_len_rom, a combinational map from 3-bit sel to (R, P) in ticks. The sequencer FSM and counter stay in cadr_clock_seq.

Test Plan:
- Reset held 40 ticks, released, sel=7, hang_n=1:
  - tpr0 on the first tick after release.
  - tpclk high for ticks 0-7.
  - tprend at t=15, tpwp high for t=17-20, cycle_completed at t=26.
  - Next tpr0 27 ticks after the first.
- Sweep sel 0..7, two cycles each: measured tpr0-to-tpr0 period = 44,44,40,32,37,29,35,27 ticks.
- Change sspeed from 3 to 0 at t=5 of a cycle: that cycle stays 32 ticks and the next cycle is 44 ticks.
- Drop hang_n at t=10 and hold for 50 ticks:
  - The cycle completes and all strobes go to 0.
  - tpr0 comes 1 tick after hang_n rises.
- Assert reset at t=20 of a cycle: all outputs 0 at the next edge; restart gives a clean tpr0.
- With CADR_CLOCK_STEP_EN, step_mode=1:
  - Three 1-tick step pulses give exactly three cycle_completed.
  - A step held 100 ticks gives one cycle.
